mem_access_unit: RTL and testbench
==================================

// Module: mem_access_unit
// PURPOSE
//  MEM-stage load/store unit directly downstream of the Execute ALU. Consumes the ALU result as an
//  effective address, or passes it through for non-memory instructions. Issues ready/valid requests
//  to data memory, aligns and extends load data, and stalls the upstream pipeline until each access completes.
// PARAMETERS
//  (none: datapath fixed at 32 bits, byte-addressed, little-endian, 4 byte lanes)
// PORTS
//  clk            in   1   clock, all state updates on rising edge
//  reset          in   1   synchronous, active-high
//  ex_valid       in   1   valid instruction presented from EX
//  ex_alu_result  in   32  ALU result / effective address
//  ex_store_data  in   32  rt value for stores
//  ex_mem_read    in   1   load
//  ex_mem_write   in   1   store; if read=write=1, treated as load
//  ex_size        in   2   00 byte, 01 half, 10/11 word
//  ex_unsigned    in   1   1 = zero-extend load (lbu/lhu)
//  stall          out  1   combinational; upstream holds ex_* stable while high
//  wb_valid       out  1   registered 1-cycle retire pulse
//  wb_alu_result  out  32  registered copy of retired ex_alu_result
//  wb_data        out  32  registered extended load data, 0 for non-loads
//  misalign       out  1   registered 1-cycle fault pulse
//  mem_req_valid  out  1   request valid
//  mem_req_ready  in   1   memory accepts request
//  mem_we         out  1   1 = write
//  mem_addr       out  32  {ex_alu_result[31:2],2'b00}
//  mem_wdata      out  32  lane-replicated store data
//  mem_wstrb      out  4   byte enables (0000 on loads)
//  mem_rsp_valid  in   1   read data valid (never in the same cycle as the request handshake)
//  mem_rdata      in   32  read data word
// BEHAVIOUR
//  Reset: state=IDLE; wb_valid, misalign, mem_req_valid, mem_we = 0; wb_*, mem_addr/wdata/wstrb = 0.
//  FSM states: IDLE, REQ, WAIT. ex_* inputs are sampled only in IDLE.
//  IDLE + ex_valid + no mem op -> next edge: wb_valid=1, wb_alu_result=ex_alu_result, wb_data=0. Latency 1, no stall.
//  IDLE + mem op + misaligned (half with a[0]=1; word with a[1:0]!=0) -> next edge: misalign=1, wb_valid=0, no request, no stall.
//  IDLE + aligned mem op -> stall=1 this cycle; capture addr/size/data/unsigned; -> REQ with mem_req_valid=1.
//  REQ: mem_req_valid and all mem_* held stable until mem_req_ready. Store + ready: stall=0 this cycle;
//   next edge: wb_valid=1, -> IDLE. Load + ready: -> WAIT (stall stays 1). mem_rsp_valid ignored in REQ.
//  WAIT: stall=1 until mem_rsp_valid. Rsp cycle: stall=0; next edge: wb_valid=1, wb_data=extended lane, -> IDLE.
//  stall = (state!=IDLE && !completing) | (IDLE & ex_valid & memop & aligned).
//   completing = REQ&store&ready | WAIT&rsp_valid.
//  Lanes: byte strb = 1<<a[1:0], wdata={4{d[7:0]}}; half strb = a[1]?1100:0011, wdata={2{d[15:0]}}; word 1111.
//  Load extraction: byte = rdata[8*a[1:0]+:8]; half = rdata[16*a[1]+:16]; sign- or zero-extend per ex_unsigned.
//  Reset mid-operation: abandon access; mem_req_valid=0 the next cycle. A late mem_rsp_valid in IDLE is ignored.
//  No back-to-back overlap: at most one outstanding access; a new op is accepted in IDLE only.
// TESTING
//  1 ex_valid, no mem op, alu_result=0x0000002A -> next cycle wb_valid=1, wb_alu_result=0x2A, wb_data=0; stall never 1.
//  2 lw a=0x100, ready immediate, rsp 2 cycles later rdata=0xDEADBEEF -> mem_addr=0x100, we=0, wb_data=0xDEADBEEF,
//    stall high from accept through the cycle before rsp.
//  3 lb a=0x103, rdata=0x80123456 -> wb_data=0xFFFFFF80; lbu same -> 0x00000080; lh a=0x102 -> 0xFFFF8012.
//  4 sh a=0x102, d=0x1234ABCD, ready low 3 cycles -> req_valid/addr 0x100/wdata 0xABCDABCD/strb 1100 held; wb_valid after ready.
//  5 lw a=0x101 -> misalign pulse 1 cycle, mem_req_valid stays 0, stall 0, wb_valid 0.
//  6 reset asserted in WAIT, rsp_valid arrives 2 cycles later -> state IDLE, wb_valid stays 0, stall 0.

Source files
------------

// File: rtl/mem_access_unit_if.sv
// Data-memory request/response bus between the MEM-stage load/store unit (master)
// and data memory (slave): one ready/valid request channel plus a read-response strobe.
interface mem_access_unit_if;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_rsp_valid;
    logic [31:0] mem_rdata;

    modport master (
        output mem_req_valid, mem_we, mem_addr, mem_wdata, mem_wstrb,
        input  mem_req_ready, mem_rsp_valid, mem_rdata
    );

    modport slave (
        input  mem_req_valid, mem_we, mem_addr, mem_wdata, mem_wstrb,
        output mem_req_ready, mem_rsp_valid, mem_rdata
    );
endinterface

// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit: issues one data-memory access at a time, aligns and
// extends load data, and stalls the upstream pipeline until the access completes.
module mem_access_unit (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      ex_valid,
    input  logic [31:0]               ex_alu_result,
    input  logic [31:0]               ex_store_data,
    input  logic                      ex_mem_read,
    input  logic                      ex_mem_write,
    input  logic [1:0]                ex_size,
    input  logic                      ex_unsigned,
    output logic                      stall,
    output logic                      wb_valid,
    output logic [31:0]               wb_alu_result,
    output logic [31:0]               wb_data,
    output logic                      misalign,
    mem_access_unit_if.master         mem
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

    state_t      state_q, state_d;
    logic [31:0] alu_q, alu_d;
    logic [1:0]  size_q, size_d;
    logic [1:0]  off_q, off_d;
    logic        uns_q, uns_d;
    logic        is_load_q, is_load_d;
    logic        wb_valid_q, wb_valid_d;
    logic [31:0] wb_alu_result_q, wb_alu_result_d;
    logic [31:0] wb_data_q, wb_data_d;
    logic        misalign_q, misalign_d;
    logic        req_valid_q, req_valid_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  wstrb_q, wstrb_d;

    logic        ex_mem_op;
    logic        ex_misaligned;
    logic [3:0]  lane_strb;
    logic [31:0] lane_wdata;
    logic [7:0]  rsp_byte;
    logic [15:0] rsp_half;
    logic [31:0] load_ext;

    // A simultaneous read+write request is treated as a load.
    assign ex_mem_op     = ex_mem_read | ex_mem_write;
    assign ex_misaligned = (ex_size == 2'b01) ? ex_alu_result[0]
                         : (ex_size[1] ? (ex_alu_result[1:0] != 2'b00) : 1'b0);

    always_comb begin
        lane_strb  = 4'b1111;
        lane_wdata = ex_store_data;
        case (ex_size)
            2'b00: begin
                lane_strb  = 4'b0001 << ex_alu_result[1:0];
                lane_wdata = {4{ex_store_data[7:0]}};
            end
            2'b01: begin
                lane_strb  = ex_alu_result[1] ? 4'b1100 : 4'b0011;
                lane_wdata = {2{ex_store_data[15:0]}};
            end
            default: ;
        endcase
        if (ex_mem_read) begin
            lane_strb = 4'b0000;
        end
    end

    always_comb begin
        rsp_byte = 8'(mem.mem_rdata >> {off_q, 3'b000});
        rsp_half = off_q[1] ? mem.mem_rdata[31:16] : mem.mem_rdata[15:0];
        case (size_q)
            2'b00:   load_ext = {{24{~uns_q & rsp_byte[7]}}, rsp_byte};
            2'b01:   load_ext = {{16{~uns_q & rsp_half[15]}}, rsp_half};
            default: load_ext = mem.mem_rdata;
        endcase
    end

    // Upstream sees stall=0 exactly in the cycle an instruction retires or faults,
    // so it may present the next instruction after that edge.
    always_comb begin
        state_d         = state_q;
        alu_d           = alu_q;
        size_d          = size_q;
        off_d           = off_q;
        uns_d           = uns_q;
        is_load_d       = is_load_q;
        wb_valid_d      = 1'b0;
        wb_alu_result_d = wb_alu_result_q;
        wb_data_d       = wb_data_q;
        misalign_d      = 1'b0;
        req_valid_d     = req_valid_q;
        we_d            = we_q;
        addr_d          = addr_q;
        wdata_d         = wdata_q;
        wstrb_d         = wstrb_q;
        stall           = 1'b0;

        case (state_q)
            IDLE: begin
                if (ex_valid) begin
                    if (!ex_mem_op) begin
                        wb_valid_d      = 1'b1;
                        wb_alu_result_d = ex_alu_result;
                        wb_data_d       = 32'h0;
                    end else if (ex_misaligned) begin
                        misalign_d = 1'b1;
                    end else begin
                        stall       = 1'b1;
                        state_d     = REQ;
                        alu_d       = ex_alu_result;
                        size_d      = ex_size;
                        off_d       = ex_alu_result[1:0];
                        uns_d       = ex_unsigned;
                        is_load_d   = ex_mem_read;
                        req_valid_d = 1'b1;
                        we_d        = ~ex_mem_read;
                        addr_d      = {ex_alu_result[31:2], 2'b00};
                        wdata_d     = lane_wdata;
                        wstrb_d     = lane_strb;
                    end
                end
            end
            REQ: begin
                stall = 1'b1;
                if (mem.mem_req_ready) begin
                    req_valid_d = 1'b0;
                    if (is_load_q) begin
                        state_d = WAIT;
                    end else begin
                        stall           = 1'b0;
                        wb_valid_d      = 1'b1;
                        wb_alu_result_d = alu_q;
                        wb_data_d       = 32'h0;
                        state_d         = IDLE;
                    end
                end
            end
            WAIT: begin
                stall = 1'b1;
                if (mem.mem_rsp_valid) begin
                    stall           = 1'b0;
                    wb_valid_d      = 1'b1;
                    wb_alu_result_d = alu_q;
                    wb_data_d       = load_ext;
                    state_d         = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= IDLE;
            alu_q           <= 32'h0;
            size_q          <= 2'b00;
            off_q           <= 2'b00;
            uns_q           <= 1'b0;
            is_load_q       <= 1'b0;
            wb_valid_q      <= 1'b0;
            wb_alu_result_q <= 32'h0;
            wb_data_q       <= 32'h0;
            misalign_q      <= 1'b0;
            req_valid_q     <= 1'b0;
            we_q            <= 1'b0;
            addr_q          <= 32'h0;
            wdata_q         <= 32'h0;
            wstrb_q         <= 4'b0000;
        end else begin
            state_q         <= state_d;
            alu_q           <= alu_d;
            size_q          <= size_d;
            off_q           <= off_d;
            uns_q           <= uns_d;
            is_load_q       <= is_load_d;
            wb_valid_q      <= wb_valid_d;
            wb_alu_result_q <= wb_alu_result_d;
            wb_data_q       <= wb_data_d;
            misalign_q      <= misalign_d;
            req_valid_q     <= req_valid_d;
            we_q            <= we_d;
            addr_q          <= addr_d;
            wdata_q         <= wdata_d;
            wstrb_q         <= wstrb_d;
        end
    end

    assign wb_valid          = wb_valid_q;
    assign wb_alu_result     = wb_alu_result_q;
    assign wb_data           = wb_data_q;
    assign misalign          = misalign_q;
    assign mem.mem_req_valid = req_valid_q;
    assign mem.mem_we        = we_q;
    assign mem.mem_addr      = addr_q;
    assign mem.mem_wdata     = wdata_q;
    assign mem.mem_wstrb     = wstrb_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboarded bench for mem_access_unit: a byte-array reference memory predicts
// retire/fault results and bus requests, a separate monitor compares them.
module tb_mem_access_unit;

    typedef struct {
        bit          mis;
        logic [31:0] alu;
        logic [31:0] data;
    } wb_exp_t;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  wstrb;
        logic [31:0] wdata;
    } req_exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        ex_valid;
    logic [31:0] ex_alu_result;
    logic [31:0] ex_store_data;
    logic        ex_mem_read;
    logic        ex_mem_write;
    logic [1:0]  ex_size;
    logic        ex_unsigned;
    logic        stall;
    logic        wb_valid;
    logic [31:0] wb_alu_result;
    logic [31:0] wb_data;
    logic        misalign;

    mem_access_unit_if mem_if ();

    mem_access_unit dut (
        .clk           (clk),
        .reset         (reset),
        .ex_valid      (ex_valid),
        .ex_alu_result (ex_alu_result),
        .ex_store_data (ex_store_data),
        .ex_mem_read   (ex_mem_read),
        .ex_mem_write  (ex_mem_write),
        .ex_size       (ex_size),
        .ex_unsigned   (ex_unsigned),
        .stall         (stall),
        .wb_valid      (wb_valid),
        .wb_alu_result (wb_alu_result),
        .wb_data       (wb_data),
        .misalign      (misalign),
        .mem           (mem_if)
    );

    always #5 clk = ~clk;

    wb_exp_t     wb_q[$];
    req_exp_t    req_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;

    logic [7:0]  ref_bytes [256];
    logic [31:0] ram [64];
    int          ready_lat = -1;
    int          rsp_lat   = -1;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int nbytes(input logic [1:0] sz);
        return (sz == 2'b00) ? 1 : ((sz == 2'b01) ? 2 : 4);
    endfunction

    function automatic logic [31:0] refLoad(input logic [31:0] a, input logic [1:0] sz, input logic us);
        int          nb;
        logic [31:0] v;
        nb = nbytes(sz);
        v  = 32'h0;
        for (int i = 0; i < nb; i++) begin
            v = v | (32'(ref_bytes[(int'(a[7:0]) + i) % 256]) << (8 * i));
        end
        if (!us && nb < 4 && v[8*nb-1]) begin
            v = v | (32'hFFFF_FFFF << (8 * nb));
        end
        return v;
    endfunction

    task automatic preloadWord(input logic [31:0] a, input logic [31:0] w);
        ram[a[7:2]] = w;
        for (int k = 0; k < 4; k++) begin
            ref_bytes[(int'(a[7:0]) & 252) + k] = w[8*k +: 8];
        end
    endtask

    // Presents one instruction (called just after a rising edge), records what the
    // unit must produce, then holds it until the unit stops stalling.
    task automatic applyStimulus(input logic [31:0] a, input logic [31:0] d, input logic rd,
                                 input logic wr, input logic [1:0] sz, input logic us);
        int       nb;
        int       off;
        bit       memop;
        bit       mis;
        bit       done;
        req_exp_t r;
        nb    = nbytes(sz);
        off   = int'(a[1:0]);
        memop = rd | wr;
        mis   = memop && ((off % nb) != 0);

        ex_valid = 1'b1; ex_alu_result = a; ex_store_data = d;
        ex_mem_read = rd; ex_mem_write = wr; ex_size = sz; ex_unsigned = us;

        if (!memop) begin
            wb_q.push_back('{mis: 1'b0, alu: a, data: 32'h0});
        end else if (mis) begin
            wb_q.push_back('{mis: 1'b1, alu: 32'h0, data: 32'h0});
        end else if (rd) begin
            r = '{we: 1'b0, addr: {a[31:2], 2'b00}, wstrb: 4'b0000, wdata: 32'h0};
            req_q.push_back(r);
            wb_q.push_back('{mis: 1'b0, alu: a, data: refLoad(a, sz, us)});
        end else begin
            r = '{we: 1'b1, addr: {a[31:2], 2'b00}, wstrb: 4'b0000, wdata: 32'h0};
            for (int j = 0; j < 4; j++) begin
                r.wdata[8*j +: 8] = d[8*(j % nb) +: 8];
                r.wstrb[j]        = (j >= off) && (j < off + nb);
            end
            for (int i = 0; i < nb; i++) begin
                ref_bytes[int'(a[7:0]) + i] = d[8*i +: 8];
            end
            req_q.push_back(r);
            wb_q.push_back('{mis: 1'b0, alu: a, data: 32'h0});
        end

        done = 1'b0;
        for (int c = 0; c < 60 && !done; c++) begin
            @(negedge clk);
            if (c == 0) begin
                checkOutput("stall_on_issue", 32'(stall), 32'(memop && !mis));
            end
            if (!stall) begin
                done = 1'b1;
                if (memop && !mis && rd) begin
                    checkOutput("load_completes_on_rsp", 32'(mem_if.mem_rsp_valid), 32'h1);
                end else if (memop && !mis) begin
                    checkOutput("store_completes_on_ready",
                                32'(mem_if.mem_req_valid & mem_if.mem_req_ready), 32'h1);
                end
            end
            @(posedge clk);
            #1;
        end
        checkOutput("instr_completed", 32'(done), 32'h1);
        ex_valid = 1'b0;
    endtask

    // Data memory responder: applies strobed writes, returns reads after a delay.
    initial begin
        bit          hs;
        logic        hs_we;
        logic [31:0] hs_addr, hs_wdata, w;
        logic [3:0]  hs_strb;
        int          rsp_cnt  = 0;
        int          req_wait = 0;
        logic [31:0] rsp_data = 32'h0;
        mem_if.mem_req_ready = 1'b0;
        mem_if.mem_rsp_valid = 1'b0;
        mem_if.mem_rdata     = 32'h0;
        forever begin
            @(negedge clk);
            hs       = (mem_if.mem_req_valid === 1'b1) && (mem_if.mem_req_ready === 1'b1);
            hs_we    = mem_if.mem_we;
            hs_addr  = mem_if.mem_addr;
            hs_wdata = mem_if.mem_wdata;
            hs_strb  = mem_if.mem_wstrb;
            if (hs) req_wait = 0;
            else if (mem_if.mem_req_valid === 1'b1) req_wait++;
            @(posedge clk);
            #1;
            if (hs) begin
                if (hs_we) begin
                    w = ram[hs_addr[7:2]];
                    for (int k = 0; k < 4; k++) begin
                        if (hs_strb[k]) w[8*k +: 8] = hs_wdata[8*k +: 8];
                    end
                    ram[hs_addr[7:2]] = w;
                end else begin
                    rsp_data = ram[hs_addr[7:2]];
                    rsp_cnt  = (rsp_lat >= 0) ? rsp_lat : int'($urandom_range(1, 3));
                end
            end
            mem_if.mem_rsp_valid = 1'b0;
            mem_if.mem_rdata     = $urandom;
            if (rsp_cnt > 0) begin
                rsp_cnt--;
                if (rsp_cnt == 0) begin
                    mem_if.mem_rsp_valid = 1'b1;
                    mem_if.mem_rdata     = rsp_data;
                end
            end
            if (ready_lat >= 0) mem_if.mem_req_ready = (mem_if.mem_req_valid === 1'b1) && (req_wait >= ready_lat);
            else                mem_if.mem_req_ready = ($urandom_range(0, 2) != 0);
        end
    end

    // Monitor: pops the scoreboard whenever the unit retires, faults or issues a request.
    initial begin
        bit          prev_hold = 1'b0;
        logic        prev_we;
        logic [31:0] prev_addr, prev_wdata;
        logic [3:0]  prev_strb;
        wb_exp_t     e;
        req_exp_t    r;
        forever begin
            @(negedge clk);
            if (reset !== 1'b0) begin
                prev_hold = 1'b0;
                continue;
            end
            if (wb_valid || misalign) begin
                if (wb_q.size() == 0) begin
                    checkOutput("unexpected_output", {30'h0, wb_valid, misalign}, 32'h0);
                end else begin
                    e = wb_q.pop_front();
                    checkOutput("fault_pulse", 32'(misalign), 32'(e.mis));
                    checkOutput("retire_pulse", 32'(wb_valid), 32'(!e.mis));
                    if (!e.mis) begin
                        checkOutput("wb_alu_result", wb_alu_result, e.alu);
                        checkOutput("wb_data", wb_data, e.data);
                    end
                end
            end
            if (mem_if.mem_req_valid && mem_if.mem_req_ready) begin
                if (req_q.size() == 0) begin
                    checkOutput("unexpected_request", 32'(mem_if.mem_req_valid), 32'h0);
                end else begin
                    r = req_q.pop_front();
                    checkOutput("mem_we", 32'(mem_if.mem_we), 32'(r.we));
                    checkOutput("mem_addr", mem_if.mem_addr, r.addr);
                    checkOutput("mem_wstrb", 32'(mem_if.mem_wstrb), 32'(r.wstrb));
                    if (r.we) checkOutput("mem_wdata", mem_if.mem_wdata, r.wdata);
                end
            end
            if (prev_hold) begin
                checkOutput("req_held_valid", 32'(mem_if.mem_req_valid), 32'h1);
                checkOutput("req_held_we", 32'(mem_if.mem_we), 32'(prev_we));
                checkOutput("req_held_addr", mem_if.mem_addr, prev_addr);
                checkOutput("req_held_wdata", mem_if.mem_wdata, prev_wdata);
                checkOutput("req_held_wstrb", 32'(mem_if.mem_wstrb), 32'(prev_strb));
            end
            prev_hold  = mem_if.mem_req_valid && !mem_if.mem_req_ready;
            prev_we    = mem_if.mem_we;
            prev_addr  = mem_if.mem_addr;
            prev_wdata = mem_if.mem_wdata;
            prev_strb  = mem_if.mem_wstrb;
        end
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [31:0] a, d;
        logic        rd, wr;
        int          gap;

        reset = 1'b1; ex_valid = 1'b0; ex_alu_result = 32'h0; ex_store_data = 32'h0;
        ex_mem_read = 1'b0; ex_mem_write = 1'b0; ex_size = 2'b00; ex_unsigned = 1'b0;
        for (int i = 0; i < 64; i++) preloadWord(32'(i * 4), $urandom);

        @(posedge clk); #1;
        @(negedge clk);
        checkOutput("reset_wb_valid", 32'(wb_valid), 32'h0);
        checkOutput("reset_misalign", 32'(misalign), 32'h0);
        checkOutput("reset_req_valid", 32'(mem_if.mem_req_valid), 32'h0);
        checkOutput("reset_we", 32'(mem_if.mem_we), 32'h0);
        checkOutput("reset_wb_alu_result", wb_alu_result, 32'h0);
        checkOutput("reset_wb_data", wb_data, 32'h0);
        checkOutput("reset_mem_addr", mem_if.mem_addr, 32'h0);
        checkOutput("reset_mem_wdata", mem_if.mem_wdata, 32'h0);
        checkOutput("reset_mem_wstrb", 32'(mem_if.mem_wstrb), 32'h0);
        checkOutput("reset_stall", 32'(stall), 32'h0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;

        $display("[TB] directed cases");
        applyStimulus(32'h0000_002A, 32'h0, 1'b0, 1'b0, 2'b10, 1'b0);
        ready_lat = 0; rsp_lat = 2;
        preloadWord(32'h100, 32'hDEAD_BEEF);
        applyStimulus(32'h0000_0100, 32'h0, 1'b1, 1'b0, 2'b10, 1'b0);
        preloadWord(32'h100, 32'h8012_3456);
        applyStimulus(32'h0000_0103, 32'h0, 1'b1, 1'b0, 2'b00, 1'b0);
        applyStimulus(32'h0000_0103, 32'h0, 1'b1, 1'b0, 2'b00, 1'b1);
        applyStimulus(32'h0000_0102, 32'h0, 1'b1, 1'b1, 2'b01, 1'b0);
        ready_lat = 3;
        applyStimulus(32'h0000_0102, 32'h1234_ABCD, 1'b0, 1'b1, 2'b01, 1'b0);
        applyStimulus(32'h0000_0101, 32'h0, 1'b1, 1'b0, 2'b10, 1'b0);
        @(negedge clk);
        checkOutput("misaligned_no_request", 32'(mem_if.mem_req_valid), 32'h0);
        @(posedge clk); #1;

        $display("[TB] reset during WAIT");
        ready_lat = 0; rsp_lat = 4;
        ex_valid = 1'b1; ex_alu_result = 32'h100; ex_mem_read = 1'b1; ex_mem_write = 1'b0;
        ex_size = 2'b10; ex_unsigned = 1'b0;
        req_q.push_back('{we: 1'b0, addr: 32'h100, wstrb: 4'b0000, wdata: 32'h0});
        @(negedge clk); checkOutput("abort_stall_idle", 32'(stall), 32'h1);
        @(posedge clk); #1;
        @(negedge clk); checkOutput("abort_stall_req", 32'(stall), 32'h1);
        @(posedge clk); #1;
        @(negedge clk); checkOutput("abort_stall_wait", 32'(stall), 32'h1);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0; ex_valid = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            checkOutput("abort_stall_low", 32'(stall), 32'h0);
            checkOutput("abort_no_retire", 32'(wb_valid), 32'h0);
            checkOutput("abort_no_request", 32'(mem_if.mem_req_valid), 32'h0);
            @(posedge clk); #1;
        end
        ready_lat = -1; rsp_lat = -1;

        $display("[TB] randomized traffic");
        for (int n = 0; n < 160; n++) begin
            a = $urandom;
            if ($urandom_range(0, 1) == 0) a[1:0] = 2'b00;
            d = $urandom;
            if ($urandom_range(0, 4) == 0) begin
                rd = 1'b0; wr = 1'b0;
            end else begin
                rd = 1'($urandom_range(0, 1));
                wr = rd ? 1'($urandom_range(0, 1)) : 1'b1;
            end
            applyStimulus(a, d, rd, wr, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
            gap = $urandom_range(0, 2);
            for (int g = 0; g < gap; g++) begin
                ex_alu_result = $urandom; ex_store_data = $urandom;
                ex_mem_read = 1'($urandom_range(0, 1)); ex_mem_write = 1'($urandom_range(0, 1));
                @(posedge clk); #1;
            end
        end

        repeat (8) @(posedge clk);
        #1;
        checkOutput("wb_queue_drained", 32'(wb_q.size()), 32'h0);
        checkOutput("req_queue_drained", 32'(req_q.size()), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
